ov_7670_capture: RTL and testbench

OV_7670_CAPTURE -- requirements
Module: ov_7670_capture

---
 rtl/ov_7670_pkg.sv | 21 ++
 rtl/ov_7670_edge.sv | 24 ++
 rtl/ov_7670_capture.sv | 212 +++++++++++++++++++++
 tb/tb_ov_7670_capture.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov_7670_pkg.sv
// Shared definitions for the OV7670 capture block: state encoding,
// default frame geometry and pixel coordinate widths.
package ov_7670_pkg;

  localparam int unsigned DEF_H_RES = 640;
  localparam int unsigned DEF_V_RES = 480;
  localparam int unsigned PIX_X_W   = 10;
  localparam int unsigned PIX_Y_W   = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_FRAME = 2'd2
  } cap_state_t;

  // The camera sends the RGB565 high byte first.
  function automatic logic [15:0] packRgb565(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ov_7670_edge.sv
// Registered edge detector: one flop of history, rise/fall compare the
// current input against the previous cycle's value.
module ov_7670_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 1'b0;
    end else begin
      r_sig <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig;
  assign o_fall = ~i_sig & r_sig;

endmodule

// File: rtl/ov_7670_capture.sv
// OV7670 DVP capture: assembles byte pairs into RGB565 pixels with x/y tags.
// Optional macro OV_CAPTURE_FRAME_SKIP_EN emits pixels on even frames only.
module ov_7670_capture
  import ov_7670_pkg::*;
#(
  parameter int unsigned H_RES = DEF_H_RES,
  parameter int unsigned V_RES = DEF_V_RES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_done,
  input  logic               vsync,
  input  logic               href,
  input  logic [7:0]         d,
  output logic [15:0]        pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_X_W-1:0] pix_x,
  output logic [PIX_Y_W-1:0] pix_y,
  output logic               frame_done,
  output logic               frame_ok,
  output logic               err
);

  localparam int unsigned XCW = PIX_X_W + 1;
  localparam int unsigned YCW = PIX_Y_W + 1;
  localparam logic [XCW-1:0] X_LIMIT = XCW'(H_RES);
  localparam logic [YCW-1:0] Y_LIMIT = YCW'(V_RES);

  cap_state_t r_state;
  cap_state_t w_nextState;

  logic w_vsRise, w_vsFall, w_hrRise, w_hrFall;
  logic w_frameActive, w_lineFull, w_rowFull, w_emit;

  logic [XCW-1:0]     r_xCnt;
  logic [YCW-1:0]     r_yCnt;
  logic               r_phase;
  logic [7:0]         r_hiByte;
  logic               r_lineSeen;
  logic               r_inLine;
  logic               r_frameBad;
  logic [15:0]        r_pixData;
  logic               r_pixValid;
  logic [PIX_X_W-1:0] r_pixX;
  logic [PIX_Y_W-1:0] r_pixY;
  logic               r_frameDone;
  logic               r_frameOk;
  logic               r_err;

  ov_7670_edge u_vsEdge (
    .clk    (clk),
    .rst_n  (reset),
    .i_sig  (vsync),
    .o_rise (w_vsRise),
    .o_fall (w_vsFall)
  );

  ov_7670_edge u_hrEdge (
    .clk    (clk),
    .rst_n  (reset),
    .i_sig  (href),
    .o_rise (w_hrRise),
    .o_fall (w_hrFall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Losing init_done overrides every state so a re-initialised camera
  // always resynchronises from a clean frame boundary.
  always_comb begin
    w_nextState = r_state;
    if (!init_done) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_nextState = S_SYNC;
        S_SYNC:  if (w_vsFall) w_nextState = S_FRAME;
        S_FRAME: if (w_vsRise) w_nextState = S_SYNC;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  assign w_frameActive = (r_state == S_FRAME) && init_done;
  assign w_lineFull    = (r_xCnt >= X_LIMIT);
  assign w_rowFull     = (r_yCnt >= Y_LIMIT);

`ifdef OV_CAPTURE_FRAME_SKIP_EN
  logic r_frameCnt;

  // Counter restarts only from idle so frame 0 is the first frame after sync.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frameCnt <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_frameCnt <= 1'b0;
    end else if (w_frameActive && w_vsRise) begin
      r_frameCnt <= ~r_frameCnt;
    end
  end

  assign w_emit = ~r_frameCnt;
`else
  assign w_emit = 1'b1;
`endif

  // Frame datapath. vsync outranks href, and a line still open when vsync
  // rises is abandoned and spoils frame_ok.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xCnt      <= '0;
      r_yCnt      <= '0;
      r_phase     <= 1'b0;
      r_hiByte    <= '0;
      r_lineSeen  <= 1'b0;
      r_inLine    <= 1'b0;
      r_frameBad  <= 1'b0;
      r_pixData   <= '0;
      r_pixValid  <= 1'b0;
      r_pixX      <= '0;
      r_pixY      <= '0;
      r_frameDone <= 1'b0;
      r_frameOk   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pixValid  <= 1'b0;
      r_frameDone <= 1'b0;
      if (!w_frameActive) begin
        r_xCnt     <= '0;
        r_yCnt     <= '0;
        r_phase    <= 1'b0;
        r_lineSeen <= 1'b0;
        r_inLine   <= 1'b0;
        r_frameBad <= 1'b0;
      end else if (w_vsRise) begin
        r_frameDone <= 1'b1;
        r_frameOk   <= !r_frameBad && !r_inLine && !r_phase && (r_yCnt == Y_LIMIT);
        r_pixY      <= '0;
        r_yCnt      <= '0;
        r_xCnt      <= '0;
        r_phase     <= 1'b0;
        r_lineSeen  <= 1'b0;
        r_inLine    <= 1'b0;
        r_frameBad  <= 1'b0;
      end else if (!vsync) begin
        if (w_hrFall) begin
          r_xCnt     <= '0;
          r_phase    <= 1'b0;
          r_inLine   <= 1'b0;
          r_lineSeen <= 1'b0;
          if (r_phase) begin
            r_err      <= 1'b1;
            r_frameBad <= 1'b1;
          end
          if (r_lineSeen) begin
            if (!w_rowFull) begin
              r_yCnt <= r_yCnt + 1'b1;
            end else begin
              r_frameBad <= 1'b1;
            end
            if (r_xCnt != X_LIMIT) begin
              r_frameBad <= 1'b1;
            end
          end
        end else if (href) begin
          if (w_hrRise) begin
            r_inLine <= 1'b1;
          end
          r_phase <= ~r_phase;
          if (!r_phase) begin
            r_hiByte <= d;
          end else begin
            r_lineSeen <= 1'b1;
            if (w_lineFull) begin
              r_err      <= 1'b1;
              r_frameBad <= 1'b1;
            end else begin
              r_xCnt <= r_xCnt + 1'b1;
              if (!w_rowFull) begin
                if (!pix_ready) begin
                  r_err      <= 1'b1;
                  r_frameBad <= 1'b1;
                end else if (w_emit) begin
                  r_pixValid <= 1'b1;
                  r_pixData  <= packRgb565(r_hiByte, d);
                  r_pixX     <= r_xCnt[PIX_X_W-1:0];
                  r_pixY     <= r_yCnt[PIX_Y_W-1:0];
                end
              end
            end
          end
        end
      end
    end
  end

  assign pix_data   = r_pixData;
  assign pix_valid  = r_pixValid;
  assign pix_x      = r_pixX;
  assign pix_y      = r_pixY;
  assign frame_done = r_frameDone;
  assign frame_ok   = r_frameOk;
  assign err        = r_err;

endmodule

// File: tb/tb_ov_7670_capture.sv
// Directed bench for ov_7670_capture on a reduced 8x4 frame geometry.
// Honours OV_CAPTURE_FRAME_SKIP_EN when the build defines it.
module tb_ov_7670_capture;

  localparam int H_TB = 8;
  localparam int V_TB = 4;
  localparam int LINE_BYTES = 2 * H_TB;

  typedef struct packed {
    logic [15:0] data;
    logic [9:0]  x;
    logic [8:0]  y;
  } pix_rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        frame_done;
  logic        frame_ok;
  logic        err;

  int testsRun = 0;
  int testsFailed = 0;
  int validCnt = 0;
  int doneCnt = 0;
  logic lastOk = 1'b0;
  pix_rec_t pixQ[$];

  ov_7670_capture #(.H_RES(H_TB), .V_RES(V_TB)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge, well away from the capturing edge.
  always @(negedge clk) begin
    if (pix_valid) begin
      validCnt++;
      pixQ.push_back({pix_data, pix_x, pix_y});
    end
    if (frame_done) begin
      doneCnt++;
      lastOk = frame_ok;
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] dv, input logic rdy);
    @(negedge clk);
    vsync = vs;
    href = hr;
    d = dv;
    pix_ready = rdy;
  endtask

  function automatic logic [7:0] byteVal(input int l, input int b);
    return 8'((l * LINE_BYTES + b) & 255);
  endfunction

  function automatic pix_rec_t getPix(input int idx);
    if (idx < pixQ.size()) return pixQ[idx];
    return '1;
  endfunction

  task automatic vsyncPulse();
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic sendLine(input int l, input int nBytes, input int dropPix);
    for (int b = 0; b < nBytes; b++)
      applyStimulus(1'b0, 1'b1, byteVal(l, b), (b == 2 * dropPix + 1) ? 1'b0 : 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic sendFrame(input int nLines, input int line0Bytes, input int dropPix);
    sendLine(0, line0Bytes, dropPix);
    for (int l = 1; l < nLines; l++) sendLine(l, LINE_BYTES, -1);
    vsyncPulse();
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    vsyncPulse();
  endtask

  initial begin
    int vBase, dBase, qBase, expPix;
    pix_rec_t p;

    reset = 1'b0;
    init_done = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    d = 8'h00;
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
    checkOutput("rst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("rst_pix_y", 32'(pix_y), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_frame_ok", 32'(frame_ok), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    reset = 1'b1;

    // Camera active but not initialised: everything ignored.
    vsyncPulse();
    sendFrame(V_TB, LINE_BYTES, -1);
    checkOutput("noinit_valid", 32'(validCnt), 32'd0);
    checkOutput("noinit_done", 32'(doneCnt), 32'd0);

    // init_done rises mid-frame: remainder of that frame is ignored.
    @(negedge clk);
    init_done = 1'b1;
    sendLine(0, LINE_BYTES, -1);
    sendLine(1, LINE_BYTES, -1);
    checkOutput("midframe_valid", 32'(validCnt), 32'd0);
    vsyncPulse();
    checkOutput("midframe_done", 32'(doneCnt), 32'd0);

    vBase = validCnt; dBase = doneCnt; qBase = pixQ.size();
    applyStimulus(1'b0, 1'b1, 8'hF8, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h1F, 1'b1);
    @(posedge clk); #1;
    checkOutput("lat_valid", 32'(pix_valid), 32'd1);
    checkOutput("lat_data", 32'(pix_data), 32'hF81F);
    checkOutput("lat_x", 32'(pix_x), 32'd0);
    checkOutput("lat_y", 32'(pix_y), 32'd0);
    for (int b = 2; b < LINE_BYTES; b++) applyStimulus(1'b0, 1'b1, byteVal(0, b), 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int l = 1; l < V_TB; l++) sendLine(l, LINE_BYTES, -1);
    vsyncPulse();
    checkOutput("good_valid_cnt", 32'(validCnt - vBase), 32'd32);
    checkOutput("good_done_cnt", 32'(doneCnt - dBase), 32'd1);
    checkOutput("good_frame_ok", 32'(lastOk), 32'd1);
    checkOutput("good_err", 32'(err), 32'd0);
    checkOutput("good_pix_y_zeroed", 32'(pix_y), 32'd0);
    p = getPix(qBase + 9);
    checkOutput("good_p9_data", 32'(p.data), 32'h1213);
    checkOutput("good_p9_xy", {p.x, 3'b0, p.y}, {10'd1, 3'b0, 9'd1});
    p = getPix(qBase + 31);
    checkOutput("good_p31_data", 32'(p.data), 32'h3E3F);
    checkOutput("good_p31_xy", {p.x, 3'b0, p.y}, {10'd7, 3'b0, 9'd3});

    // Odd byte count on line 0.
    resetDut();
    vBase = validCnt; dBase = doneCnt; qBase = pixQ.size();
    sendFrame(V_TB, LINE_BYTES + 1, -1);
    checkOutput("odd_valid_cnt", 32'(validCnt - vBase), 32'd32);
    checkOutput("odd_done_cnt", 32'(doneCnt - dBase), 32'd1);
    checkOutput("odd_err", 32'(err), 32'd1);
    checkOutput("odd_frame_ok", 32'(lastOk), 32'd0);
    p = getPix(qBase + 8);
    checkOutput("odd_p8_xy", {p.x, 3'b0, p.y}, {10'd0, 3'b0, 9'd1});

    // Asynchronous reset in the middle of a line.
    for (int b = 0; b < 4; b++) applyStimulus(1'b0, 1'b1, byteVal(0, b), 1'b1);
    @(posedge clk); #1;
    checkOutput("prerst_valid", 32'(pix_valid), 32'd1);
    checkOutput("prerst_x", 32'(pix_x), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(pix_valid), 32'd0);
    checkOutput("async_rst_x", 32'(pix_x), 32'd0);
    checkOutput("async_rst_err", 32'(err), 32'd0);
    checkOutput("async_rst_data", 32'(pix_data), 32'd0);

    // Back-pressure on pixel 5 of line 0.
    resetDut();
    vBase = validCnt; qBase = pixQ.size();
    sendFrame(V_TB, LINE_BYTES, 5);
    checkOutput("bp_valid_cnt", 32'(validCnt - vBase), 32'd31);
    p = getPix(qBase + 4);
    checkOutput("bp_p4_x", 32'(p.x), 32'd4);
    p = getPix(qBase + 5);
    checkOutput("bp_p5_x", 32'(p.x), 32'd6);
    checkOutput("bp_p5_data", 32'(p.data), 32'h0C0D);
    checkOutput("bp_err", 32'(err), 32'd1);
    checkOutput("bp_frame_ok", 32'(lastOk), 32'd0);

    // One line too many: dropped, frame not ok, but no error flag.
    resetDut();
    vBase = validCnt; dBase = doneCnt;
    sendFrame(V_TB + 1, LINE_BYTES, -1);
    checkOutput("xline_valid_cnt", 32'(validCnt - vBase), 32'd32);
    checkOutput("xline_done_cnt", 32'(doneCnt - dBase), 32'd1);
    checkOutput("xline_err", 32'(err), 32'd0);
    checkOutput("xline_frame_ok", 32'(lastOk), 32'd0);

    // Too few lines.
    resetDut();
    vBase = validCnt;
    sendFrame(V_TB - 1, LINE_BYTES, -1);
    checkOutput("short_valid_cnt", 32'(validCnt - vBase), 32'd24);
    checkOutput("short_frame_ok", 32'(lastOk), 32'd0);
    checkOutput("short_err", 32'(err), 32'd0);

    // Oversize line: pixels past the last column are dropped.
    resetDut();
    vBase = validCnt; qBase = pixQ.size();
    sendFrame(V_TB, LINE_BYTES + 4, -1);
    checkOutput("wide_valid_cnt", 32'(validCnt - vBase), 32'd32);
    p = getPix(qBase + 8);
    checkOutput("wide_p8_xy", {p.x, 3'b0, p.y}, {10'd0, 3'b0, 9'd1});
    checkOutput("wide_err", 32'(err), 32'd1);
    checkOutput("wide_frame_ok", 32'(lastOk), 32'd0);

    // init_done drops mid-frame: no frame_done, nothing further emitted.
    resetDut();
    sendLine(0, LINE_BYTES, -1);
    vBase = validCnt; dBase = doneCnt;
    @(negedge clk);
    init_done = 1'b0;
    sendLine(1, LINE_BYTES, -1);
    vsyncPulse();
    checkOutput("initdrop_valid", 32'(validCnt - vBase), 32'd0);
    checkOutput("initdrop_done", 32'(doneCnt - dBase), 32'd0);
    @(negedge clk);
    init_done = 1'b1;
    vsyncPulse();

    // Four consecutive frames.
    dBase = doneCnt;
    for (int f = 0; f < 4; f++) begin
      vBase = validCnt;
      sendFrame(V_TB, LINE_BYTES, -1);
`ifdef OV_CAPTURE_FRAME_SKIP_EN
      expPix = (f % 2 == 0) ? 32 : 0;
`else
      expPix = 32;
`endif
      checkOutput($sformatf("multi_f%0d_valid", f), 32'(validCnt - vBase), 32'(expPix));
    end
    checkOutput("multi_done_cnt", 32'(doneCnt - dBase), 32'd4);
    checkOutput("multi_last_ok", 32'(lastOk), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
